// File: rtl/gcd_req_seq_if.sv
// rtl/gcd_req_seq_if.sv - request/core/response signal bundle for gcd_req_seq
//
// Ports (slave = sequencer view):
//   request  : req_valid_i, req_a_i, req_b_i in; req_ready_o out
//   core     : gcd_result_i, gcd_done_i in; gcd_operand_a_o, gcd_operand_b_o, gcd_enable_o out
//   response : rsp_ready_i in; rsp_valid_o, rsp_gcd_o, rsp_a_o, rsp_b_o, rsp_err_o out
//   status   : count_o out (FIFO occupancy)
interface gcd_req_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] req_a_i;
  logic [DATA_WIDTH-1:0] req_b_i;

  logic [DATA_WIDTH-1:0] gcd_operand_a_o;
  logic [DATA_WIDTH-1:0] gcd_operand_b_o;
  logic                  gcd_enable_o;
  logic [DATA_WIDTH-1:0] gcd_result_i;
  logic                  gcd_done_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_gcd_o;
  logic [DATA_WIDTH-1:0] rsp_a_o;
  logic [DATA_WIDTH-1:0] rsp_b_o;
  logic                  rsp_err_o;

  logic [CW-1:0]         count_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i,
    output req_ready_o,
    output gcd_operand_a_o, gcd_operand_b_o, gcd_enable_o,
    input  gcd_result_i, gcd_done_i,
    output rsp_valid_o, rsp_gcd_o, rsp_a_o, rsp_b_o, rsp_err_o,
    input  rsp_ready_i,
    output count_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i,
    input  req_ready_o,
    input  gcd_operand_a_o, gcd_operand_b_o, gcd_enable_o,
    output gcd_result_i, gcd_done_i,
    input  rsp_valid_o, rsp_gcd_o, rsp_a_o, rsp_b_o, rsp_err_o,
    output rsp_ready_i,
    input  count_o
  );
endinterface

// File: rtl/gcd_req_seq.sv
// rtl/gcd_req_seq.sv - queued operand-pair sequencer driving an external GCD core
//
// Ports:
//   clk_i    in  sole clock, rising edge
//   reset_i  in  synchronous active-high reset
//   bus      gcd_req_seq_if.slave: request FIFO input, core launch/result, response output
module gcd_req_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int MAX_CYCLES = 256
) (
  input  logic          clk_i,
  input  logic          reset_i,
  gcd_req_seq_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int CYC_W = $clog2(MAX_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem_a [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_b [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_req_ready;

  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [DATA_WIDTH-1:0] r_rsp_gcd;
  logic                  r_rsp_err;
  logic [CYC_W-1:0]      r_cyc;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_nempty;
  logic [DATA_WIDTH-1:0] w_head_a;
  logic [DATA_WIDTH-1:0] w_head_b;
  logic                  w_head_bypass;
  logic                  w_wd_expire;
  logic                  w_enable;
  logic                  w_rsp_valid;

  // Ready is a registered copy of "not full", so a full FIFO refuses a push
  // even in a cycle where the sequencer pops.
  assign w_push        = bus.req_valid_i && r_req_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head_a      = r_mem_a[r_rd_ptr];
  assign w_head_b      = r_mem_b[r_rd_ptr];
  // A zero operand makes the answer trivial, so the core is never started.
  assign w_head_bypass = (w_head_a == '0) || (w_head_b == '0);
  assign w_wd_expire   = (r_cyc == CYC_LAST);
  assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_enable    = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_bypass ? S_RESP : S_RUN;
        end
      end
      S_RUN: begin
        w_enable = 1'b1;
        if (bus.gcd_done_i || w_wd_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Storage array carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= bus.req_a_i;
      r_mem_b[r_wr_ptr] <= bus.req_b_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rsp_gcd <= '0;
      r_rsp_err <= 1'b0;
      r_cyc     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op_a    <= w_head_a;
            r_op_b    <= w_head_b;
            r_rsp_err <= 1'b0;
            r_cyc     <= '0;
            if (w_head_bypass) begin
              r_rsp_gcd <= w_head_a | w_head_b;
            end
          end
        end
        S_RUN: begin
          if (bus.gcd_done_i) begin
            r_rsp_gcd <= bus.gcd_result_i;
            r_rsp_err <= 1'b0;
          end else if (w_wd_expire) begin
            r_rsp_gcd <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready_o     = r_req_ready;
  assign bus.count_o         = r_count;
  assign bus.gcd_operand_a_o = r_op_a;
  assign bus.gcd_operand_b_o = r_op_b;
  assign bus.gcd_enable_o    = w_enable;
  assign bus.rsp_valid_o     = w_rsp_valid;
  assign bus.rsp_gcd_o       = r_rsp_gcd;
  assign bus.rsp_a_o         = r_op_a;
  assign bus.rsp_b_o         = r_op_b;
  assign bus.rsp_err_o       = r_rsp_err;

endmodule

// File: tb/tb_gcd_req_seq.sv
// tb/tb_gcd_req_seq.sv - scoreboard bench for gcd_req_seq with a behavioural GCD core
module tb_gcd_req_seq;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXC  = 16;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] g;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gcd_req_seq_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  gcd_req_seq #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int core_lat   = 5;
  bit core_stuck = 1'b0;
  int run_cnt    = 0;
  int en_total   = 0;

  function automatic logic [DW-1:0] gcd_f(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural core: raises done in its core_lat-th enabled cycle unless stuck.
  always @(negedge clk) begin
    if (bus.gcd_enable_o === 1'b1) begin
      en_total++;
      run_cnt++;
      if (!core_stuck && run_cnt == core_lat) begin
        bus.gcd_done_i   = 1'b1;
        bus.gcd_result_i = gcd_f(bus.gcd_operand_a_o, bus.gcd_operand_b_o);
      end else begin
        bus.gcd_done_i   = 1'b0;
        bus.gcd_result_i = '0;
      end
    end else begin
      run_cnt          = 0;
      bus.gcd_done_i   = 1'b0;
      bus.gcd_result_i = '0;
    end
  end

  function automatic exp_t make_exp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (a == 0 || b == 0) begin
      e.g = a | b; e.err = 1'b0;
    end else if (core_stuck) begin
      e.g = '0; e.err = 1'b1;
    end else begin
      e.g = gcd_f(a, b); e.err = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at a negedge after the accepting edge.
  task automatic push_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rec);
    int w = 0;
    while (bus.req_ready_o !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.req_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL push_ready: req_ready_o=%0b after %0d cycles, required 1", bus.req_ready_o, w);
    end else begin
      bus.req_valid_i = 1'b1;
      bus.req_a_i     = a;
      bus.req_b_i     = b;
      @(posedge clk);
      if (rec) sb.push_back(make_exp(a, b));
      @(negedge clk);
      bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic check_rsp(input string name, input int max_wait);
    int   w = 0;
    exp_t e;
    while (bus.rsp_valid_o !== 1'b1 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (bus.rsp_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: rsp_valid_o=%0b after %0d cycles, required 1", name, bus.rsp_valid_o, w);
      return;
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s_unexpected: response gcd=%0d with empty scoreboard, required none", name, bus.rsp_gcd_o);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.rsp_gcd_o !== e.g) begin
        n_err++; $display("FAIL %s_gcd: got %0d, required %0d", name, bus.rsp_gcd_o, e.g);
      end
      n_cmp++;
      if (bus.rsp_a_o !== e.a || bus.rsp_b_o !== e.b) begin
        n_err++; $display("FAIL %s_ab: got (%0d,%0d), required (%0d,%0d)", name, bus.rsp_a_o, bus.rsp_b_o, e.a, e.b);
      end
      n_cmp++;
      if (bus.rsp_err_o !== e.err) begin
        n_err++; $display("FAIL %s_err: got %0b, required %0b", name, bus.rsp_err_o, e.err);
      end
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 1'b0 || bus.count_o !== '0) begin
      n_err++; $display("FAIL reset_fifo: ready=%0b count=%0d, required 0/0", bus.req_ready_o, bus.count_o);
    end
    n_cmp++;
    if (bus.gcd_enable_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: en=%0b valid=%0b err=%0b, required 0/0/0", bus.gcd_enable_o, bus.rsp_valid_o, bus.rsp_err_o);
    end
    n_cmp++;
    if ({bus.rsp_gcd_o, bus.rsp_a_o, bus.rsp_b_o, bus.gcd_operand_a_o, bus.gcd_operand_b_o} !== '0) begin
      n_err++; $display("FAIL reset_data: gcd=%0d a=%0d b=%0d, required all 0", bus.rsp_gcd_o, bus.rsp_a_o, bus.rsp_b_o);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 1'b1 || bus.count_o !== '0) begin
      n_err++; $display("FAIL post_reset_ready: ready=%0b count=%0d, required 1/0", bus.req_ready_o, bus.count_o);
    end
  endtask

  task automatic test_gcd_run();
    int e0;
    core_lat = 5;
    e0 = en_total;
    bus.req_valid_i = 1'b1; bus.req_a_i = 8'd48; bus.req_b_i = 8'd18;
    @(posedge clk);
    sb.push_back(make_exp(8'd48, 8'd18));
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n_cmp++;
    if (bus.gcd_enable_o !== 1'b0 || bus.count_o !== 1) begin
      n_err++; $display("FAIL run_t1: en=%0b count=%0d, required 0/1", bus.gcd_enable_o, bus.count_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.gcd_enable_o !== 1'b1 || bus.count_o !== 0) begin
      n_err++; $display("FAIL run_t2: en=%0b count=%0d, required 1/0", bus.gcd_enable_o, bus.count_o);
    end
    check_rsp("run48_18", 64);
    n_cmp++;
    if (en_total - e0 !== 5) begin
      n_err++; $display("FAIL run_en_cycles: got %0d, required 5", en_total - e0);
    end
  endtask

  task automatic test_bypass();
    int e0;
    e0 = en_total;
    bus.req_valid_i = 1'b1; bus.req_a_i = 8'd0; bus.req_b_i = 8'd35;
    @(posedge clk);
    sb.push_back(make_exp(8'd0, 8'd35));
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n_cmp++;
    if (bus.rsp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL bypass_t1: rsp_valid=%0b, required 0", bus.rsp_valid_o);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rsp_valid_o !== 1'b1) begin
      n_err++; $display("FAIL bypass_t2: rsp_valid=%0b, required 1", bus.rsp_valid_o);
    end
    check_rsp("bypass0_35", 8);
    push_pair(8'd0, 8'd0, 1'b1);
    check_rsp("bypass0_0", 8);
    push_pair(8'd77, 8'd0, 1'b1);
    check_rsp("bypass77_0", 8);
    n_cmp++;
    if (en_total - e0 !== 0) begin
      n_err++; $display("FAIL bypass_enable: enable cycles %0d, required 0", en_total - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] pa [5];
    logic [DW-1:0] pb [5];
    pa = '{8'd12, 8'd9, 8'd0, 8'd20, 8'd14};
    pb = '{8'd8,  8'd6, 8'd7, 8'd15, 8'd21};
    core_lat = 3;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_pair(pa[i], pb[i], 1'b1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus.count_o !== DEPTH || bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_full: count=%0d ready=%0b valid=%0b, required 4/0/1", bus.count_o, bus.req_ready_o, bus.rsp_valid_o);
    end
    bus.req_valid_i = 1'b1; bus.req_a_i = 8'd40; bus.req_b_i = 8'd24;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.count_o !== DEPTH || bus.req_ready_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_stall: count=%0d ready=%0b, required 4/0", bus.count_o, bus.req_ready_o);
    end
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) check_rsp($sformatf("b2b%0d", i), 64);
  endtask

  task automatic test_watchdog();
    int e0;
    core_stuck = 1'b1;
    e0 = en_total;
    push_pair(8'd30, 8'd12, 1'b1);
    check_rsp("wd_abort", 64);
    n_cmp++;
    if (en_total - e0 !== MAXC) begin
      n_err++; $display("FAIL wd_en_cycles: got %0d, required %0d", en_total - e0, MAXC);
    end
    core_stuck = 1'b0;
    core_lat = 4;
    e0 = en_total;
    push_pair(8'd30, 8'd12, 1'b1);
    check_rsp("wd_after", 64);
    n_cmp++;
    if (en_total - e0 !== 4) begin
      n_err++; $display("FAIL wd_after_en: got %0d, required 4", en_total - e0);
    end
  endtask

  task automatic test_reset_midrun();
    int seen = 0;
    core_lat = 100;
    push_pair(8'd40, 8'd30, 1'b0);
    push_pair(8'd50, 8'd20, 1'b0);
    push_pair(8'd60, 8'd45, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.gcd_enable_o !== 1'b1 || bus.count_o !== 2) begin
      n_err++; $display("FAIL midrun_pre: en=%0b count=%0d, required 1/2", bus.gcd_enable_o, bus.count_o);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.gcd_enable_o !== 1'b0 || bus.count_o !== 0 || bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset: en=%0b count=%0d valid=%0b ready=%0b, required 0/0/0/0",
                        bus.gcd_enable_o, bus.count_o, bus.rsp_valid_o, bus.req_ready_o);
    end
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b0 || bus.gcd_enable_o !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++; $display("FAIL midrun_quiet: %0d active cycles after reset, required 0", seen);
    end
    core_lat = 3;
    push_pair(8'd21, 8'd14, 1'b1);
    check_rsp("midrun_after", 64);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    reset            = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_a_i      = '0;
    bus.req_b_i      = '0;
    bus.rsp_ready_i  = 1'b0;
    test_reset();
    test_gcd_run();
    test_bypass();
    test_back_to_back();
    test_watchdog();
    test_reset_midrun();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
